icache: RTL and testbench
=========================

# icache

Direct-mapped, one-word-per-line instruction cache between the instruction fetch unit and the memory controller's IC port. It serves fetch requests in one cycle on a hit. On a miss it issues a single 32-bit word read to the memory controller, fills the line, and forwards the word to fetch. It also absorbs pipeline flushes, so a redirected fetch never receives a stale instruction.

## Interface
Parameters:
- `IDX_BITS`, default 8: index width; the cache holds 2^IDX_BITS lines of one word each (1 KiB).
- `ADDR_W`, default 32: byte address width.

Ports:
- `clk` in, 1: system clock; all state on posedge.
- `rst` in, 1: reset, asynchronous and active-low (0 = reset).
- `rdy` in, 1: global ready; when low, all state and outputs hold.
- `if_req` in, 1: fetch request valid this cycle.
- `if_addr` in, ADDR_W: fetch byte address, word-aligned (bits [1:0] ignored).
- `flush` in, 1: discard any outstanding fetch (branch redirect).
- `if_valid` out, 1: one-cycle pulse, `if_inst` valid.
- `if_inst` out, 32: instruction word.
- `if_busy` out, 1: cache cannot accept `if_req` this cycle.
- `mc_rn` out, 1: read request to the memory controller.
- `mc_addr` out, 32: word byte address to the memory controller.
- `mc_ready` in, 1: memory controller IC-side idle/done flag.
- `mc_value` in, 32: word returned by the memory controller.

## Operation
- Address split: index = `if_addr[IDX_BITS+1:2]`, tag = `if_addr[ADDR_W-1:IDX_BITS+2]`.
- Storage per line: valid bit, tag, 32-bit data. All valid bits clear on reset; data and tag are not reset.
- States:
  - **IDLE**: accepts requests.
    - Hit: next cycle `if_valid`=1 and `if_inst`=line data.
    - Miss: latch address, drive `mc_rn`=1 and `mc_addr` = address with [1:0] forced to 0, then go to WAIT_BUSY.
  - **WAIT_BUSY**: hold `mc_rn` and `mc_addr`. Move to WAIT_DONE on the first posedge where `mc_ready`=0. This guards against the stale "ready" left over from the previous transfer.
  - **WAIT_DONE**: hold request. On a posedge with `mc_ready`=1:
    - write tag/data/valid from `mc_value`;
    - drop `mc_rn`;
    - if the request was not cancelled, pulse `if_valid` with `if_inst`=`mc_value`;
    - go to IDLE.
- `if_busy`=1 in WAIT_BUSY and WAIT_DONE; `if_req` is ignored while busy.
- Flush:
  - In IDLE: cancels any hit response scheduled for the next cycle. Flush wins over a same-cycle `if_req`, which is dropped.
  - In WAIT_*: sets a cancel flag. The memory read runs to completion and the line is still filled, but `if_valid` is suppressed. The cancel flag clears on return to IDLE.
- Only one outstanding miss; no prefetch; no write path (self-modifying code unsupported).

## Timing
- Reset values: `if_valid`=0, `if_inst`=0, `if_busy`=0, `mc_rn`=0, `mc_addr`=0, state=IDLE, cancel=0, all valid bits 0.
- Hit latency: request at posedge N, `if_valid` at posedge N+1. Back-to-back hits run every cycle.
- Miss latency: memory controller latency + 1 cycle for the fill/response. First request possible in IDLE the cycle after `if_valid`.
- `mc_addr` is stable for the whole time `mc_rn`=1; it never changes mid-transfer.
- Reset asserted mid-miss: return to IDLE immediately with `mc_rn`=0. Any in-flight controller transfer is abandoned and its result ignored.
- `rdy`=0: FSM, arrays, and outputs frozen; an `if_valid` pulse stays asserted until the next `rdy`=1 edge.
- Simultaneous `mc_ready`=1 and `flush` in WAIT_DONE: fill occurs, response suppressed.

## Structure
- Shared constants in `constants.v` (the existing include): `True`/`False`, `Data_Bus`, plus new ICache state encodings `IC_IDLE`, `IC_WAIT_BUSY`, `IC_WAIT_DONE`.
- One sub-module is natural: `icache_array`, holding the tag/valid/data storage with a combinational read port and a synchronous write port. It owns the reset clear of the valid bits. The FSM stays in `icache`.

## Test plan
- Cold miss: reset, `if_req` at 0x0000_0000, memory returns 0x0000_0093. Required: `mc_rn`=1 with `mc_addr`=0x0; after `mc_ready` goes low then high, `if_valid` pulses once with 0x0000_0093.
- Hit: repeat 0x0000_0000. Required: `if_valid`=1 the next cycle with 0x0000_0093 and no `mc_rn` assertion.
- Conflict: fetch 0x0000_0400 (same index, different tag), memory returns 0x0010_0113. Required: a miss is issued; a later fetch of 0x0000_0000 misses again.
- Flush during miss: `flush`=1 while in WAIT_DONE. Required: no `if_valid`; a later fetch of the same address hits.
- `rdy` stall: drop `rdy` for 3 cycles mid-miss. Required: `mc_rn`, `mc_addr`, and state unchanged; completion resumes afterwards.
- Reset mid-miss: assert `rst`=0 in WAIT_BUSY. Required: `mc_rn`=0 immediately, `if_busy`=0, and the previously filled address 0x0 misses after reset.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared constants and FSM state encoding for the direct-mapped instruction cache.
package icache_pkg;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  localparam int Data_Bus = 32;

  typedef enum logic [1:0] {
    IC_IDLE      = 2'd0,
    IC_WAIT_BUSY = 2'd1,
    IC_WAIT_DONE = 2'd2
  } ic_state_e;

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: combinational read port, synchronous write port.
// Only the valid bits are reset; tag and data come up undefined.
module icache_array
  import icache_pkg::*;
#(
  parameter int IDX_BITS = 8,
  parameter int TAG_W    = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] i_rd_idx,
  output logic                o_rd_valid,
  output logic [TAG_W-1:0]    o_rd_tag,
  output logic [Data_Bus-1:0] o_rd_data,
  input  logic                i_wr_en,
  input  logic [IDX_BITS-1:0] i_wr_idx,
  input  logic [TAG_W-1:0]    i_wr_tag,
  input  logic [Data_Bus-1:0] i_wr_data
);

  localparam int LINES = 1 << IDX_BITS;

  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [Data_Bus-1:0] r_data [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= True;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding
// miss to the memory controller and flush-based response cancellation.
module icache
  import icache_pkg::*;
#(
  parameter int IDX_BITS = 8,
  parameter int ADDR_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                flush,
  output logic                if_valid,
  output logic [Data_Bus-1:0] if_inst,
  output logic                if_busy,
  output logic                mc_rn,
  output logic [31:0]         mc_addr,
  input  logic                mc_ready,
  input  logic [Data_Bus-1:0] mc_value,
  output logic [1:0]          dbg_state
);

  localparam int TAG_W = ADDR_W - IDX_BITS - 2;

  ic_state_e           r_state, w_state_nxt;
  logic                r_cancel, w_cancel_nxt;
  logic                r_if_valid, w_valid_nxt;
  logic [Data_Bus-1:0] r_if_inst, w_inst_nxt;
  logic                r_mc_rn, w_rn_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                w_fill;

  logic                w_rd_valid;
  logic [TAG_W-1:0]    w_rd_tag;
  logic [Data_Bus-1:0] w_rd_data;
  logic                w_hit;

  icache_array #(
    .IDX_BITS(IDX_BITS),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .i_rd_idx  (if_addr[IDX_BITS+1:2]),
    .o_rd_valid(w_rd_valid),
    .o_rd_tag  (w_rd_tag),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_fill && rdy),
    .i_wr_idx  (r_addr[IDX_BITS+1:2]),
    .i_wr_tag  (r_addr[ADDR_W-1:IDX_BITS+2]),
    .i_wr_data (mc_value)
  );

  assign w_hit = w_rd_valid && (w_rd_tag == if_addr[ADDR_W-1:IDX_BITS+2]);

  // A flush seen at any point of a miss suppresses the response, including
  // one arriving in the same cycle as the memory controller's done flag.
  always_comb begin
    w_state_nxt  = r_state;
    w_cancel_nxt = r_cancel;
    w_valid_nxt  = False;
    w_inst_nxt   = r_if_inst;
    w_rn_nxt     = r_mc_rn;
    w_addr_nxt   = r_addr;
    w_fill       = False;
    case (r_state)
      IC_IDLE: begin
        if (!flush && if_req) begin
          if (w_hit) begin
            w_valid_nxt = True;
            w_inst_nxt  = w_rd_data;
          end else begin
            w_rn_nxt    = True;
            w_addr_nxt  = if_addr & ~ADDR_W'(3);
            w_state_nxt = IC_WAIT_BUSY;
          end
        end
      end
      IC_WAIT_BUSY: begin
        if (flush) w_cancel_nxt = True;
        if (!mc_ready) w_state_nxt = IC_WAIT_DONE;
      end
      IC_WAIT_DONE: begin
        if (mc_ready) begin
          w_fill       = True;
          w_rn_nxt     = False;
          w_cancel_nxt = False;
          w_state_nxt  = IC_IDLE;
          if (!(r_cancel || flush)) begin
            w_valid_nxt = True;
            w_inst_nxt  = mc_value;
          end
        end else if (flush) begin
          w_cancel_nxt = True;
        end
      end
      default: w_state_nxt = IC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IC_IDLE;
      r_cancel   <= False;
      r_if_valid <= False;
      r_if_inst  <= '0;
      r_mc_rn    <= False;
      r_addr     <= '0;
    end else if (rdy) begin
      r_state    <= w_state_nxt;
      r_cancel   <= w_cancel_nxt;
      r_if_valid <= w_valid_nxt;
      r_if_inst  <= w_inst_nxt;
      r_mc_rn    <= w_rn_nxt;
      r_addr     <= w_addr_nxt;
    end
  end

  assign if_valid  = r_if_valid;
  assign if_inst   = r_if_inst;
  assign if_busy   = (r_state != IC_IDLE);
  assign mc_rn     = r_mc_rn;
  assign mc_addr   = 32'(r_addr);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: misses, hits, conflicts, flushes, rdy stalls and
// reset mid-miss, with the memory controller handshake driven by hand.
module tb_icache;
  import icache_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        flush = 1'b0;
  logic        mc_ready = 1'b1;
  logic [31:0] mc_value = '0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        if_busy;
  logic        mc_rn;
  logic [31:0] mc_addr;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errs   = 0;

  icache #(.IDX_BITS(8), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .flush    (flush),
    .if_valid (if_valid),
    .if_inst  (if_inst),
    .if_busy  (if_busy),
    .mc_rn    (mc_rn),
    .mc_addr  (mc_addr),
    .mc_ready (mc_ready),
    .mc_value (mc_value),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks; inputs change and outputs are sampled on negedges
  task automatic expect_hit(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    @(negedge clk);
    if_req = 1'b0;
    check("hit_valid", 32'(if_valid), 32'd1);
    check("hit_inst", if_inst, data);
    check("hit_no_rn", 32'(mc_rn), 32'd0);
    @(negedge clk);
    check("hit_pulse_end", 32'(if_valid), 32'd0);
  endtask

  task automatic start_miss(input logic [31:0] addr);
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    @(negedge clk);
    if_req = 1'b0;
    check("miss_rn", 32'(mc_rn), 32'd1);
    check("miss_addr", mc_addr, addr & 32'hFFFF_FFFC);
    check("miss_busy", 32'(if_busy), 32'd1);
    check("miss_state", 32'(dbg_state), 32'(IC_WAIT_BUSY));
    check("miss_no_valid", 32'(if_valid), 32'd0);
  endtask

  task automatic finish_miss(input logic [31:0] addr, input logic [31:0] value);
    mc_ready = 1'b0;
    @(negedge clk);
    check("wait_done_state", 32'(dbg_state), 32'(IC_WAIT_DONE));
    check("wait_done_addr", mc_addr, addr & 32'hFFFF_FFFC);
    mc_ready = 1'b1; mc_value = value;
    @(negedge clk);
    check("fill_valid", 32'(if_valid), 32'd1);
    check("fill_inst", if_inst, value);
    check("fill_rn_drop", 32'(mc_rn), 32'd0);
    check("fill_not_busy", 32'(if_busy), 32'd0);
    @(negedge clk);
    check("fill_pulse_end", 32'(if_valid), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_inst", if_inst, 32'd0);
    check("rst_busy", 32'(if_busy), 32'd0);
    check("rst_rn", 32'(mc_rn), 32'd0);
    check("rst_addr", mc_addr, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IC_IDLE));
    rst = 1'b1;

    // cold miss, then hits (low address bits ignored)
    start_miss(32'h0000_0000);
    finish_miss(32'h0000_0000, 32'h0000_0093);
    expect_hit(32'h0000_0000, 32'h0000_0093);
    expect_hit(32'h0000_0002, 32'h0000_0093);

    // conflict on index 0
    start_miss(32'h0000_0400);
    finish_miss(32'h0000_0400, 32'h0010_0113);
    expect_hit(32'h0000_0400, 32'h0010_0113);
    start_miss(32'h0000_0000);
    finish_miss(32'h0000_0000, 32'h0000_0093);

    // back-to-back hits
    start_miss(32'h0000_0004);
    finish_miss(32'h0000_0004, 32'hAAAA_0004);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0000;
    @(negedge clk);
    if_addr = 32'h0000_0004;
    check("b2b_valid0", 32'(if_valid), 32'd1);
    check("b2b_inst0", if_inst, 32'h0000_0093);
    @(negedge clk);
    if_req = 1'b0;
    check("b2b_valid1", 32'(if_valid), 32'd1);
    check("b2b_inst1", if_inst, 32'hAAAA_0004);
    @(negedge clk);
    check("b2b_end", 32'(if_valid), 32'd0);

    // flush in idle drops a same-cycle hit request
    if_req = 1'b1; if_addr = 32'h0000_0000; flush = 1'b1;
    @(negedge clk);
    if_req = 1'b0; flush = 1'b0;
    check("idle_flush_valid", 32'(if_valid), 32'd0);
    check("idle_flush_rn", 32'(mc_rn), 32'd0);

    // flush while in WAIT_DONE
    start_miss(32'h0000_0010);
    mc_ready = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("wd_flush_state", 32'(dbg_state), 32'(IC_WAIT_DONE));
    mc_ready = 1'b1; mc_value = 32'h0000_0011;
    @(negedge clk);
    check("wd_flush_valid", 32'(if_valid), 32'd0);
    check("wd_flush_busy", 32'(if_busy), 32'd0);
    check("wd_flush_rn", 32'(mc_rn), 32'd0);
    expect_hit(32'h0000_0010, 32'h0000_0011);

    // flush coincident with mc_ready
    start_miss(32'h0000_0020);
    mc_ready = 1'b0;
    @(negedge clk);
    mc_ready = 1'b1; mc_value = 32'h0000_0022; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("co_flush_valid", 32'(if_valid), 32'd0);
    check("co_flush_state", 32'(dbg_state), 32'(IC_IDLE));
    expect_hit(32'h0000_0020, 32'h0000_0022);

    // rdy stall mid-miss
    start_miss(32'h0000_0030);
    rdy = 1'b0; mc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_rn", 32'(mc_rn), 32'd1);
      check("stall_addr", mc_addr, 32'h0000_0030);
      check("stall_state", 32'(dbg_state), 32'(IC_WAIT_BUSY));
    end
    rdy = 1'b1;
    @(negedge clk);
    check("stall_resume", 32'(dbg_state), 32'(IC_WAIT_DONE));
    mc_ready = 1'b1; mc_value = 32'h0000_0033;
    @(negedge clk);
    check("stall_fill_valid", 32'(if_valid), 32'd1);
    check("stall_fill_inst", if_inst, 32'h0000_0033);
    rdy = 1'b0;
    @(negedge clk);
    check("stall_valid_held", 32'(if_valid), 32'd1);
    rdy = 1'b1;
    @(negedge clk);
    check("stall_valid_end", 32'(if_valid), 32'd0);

    // asynchronous reset mid-miss
    start_miss(32'h0000_0044);
    rst = 1'b0;
    #1;
    check("arst_rn", 32'(mc_rn), 32'd0);
    check("arst_busy", 32'(if_busy), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(IC_IDLE));
    check("arst_addr", mc_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    start_miss(32'h0000_0000);
    finish_miss(32'h0000_0000, 32'h0000_0093);
    expect_hit(32'h0000_0000, 32'h0000_0093);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
